// File: rtl/stage_id_pkg.sv
// -----------------------------------------------------------------------------
// stage_id_pkg
// Shared definitions for the RV32I decode stage:
//   - global widths BUS_W / REG_ADDR_W
//   - RV32I opcode, funct3 and funct7 constants
//   - 4-bit ALU operation codes consumed by the execute stage
//   - decoder output record (dec_t) and ID/EX register record (idex_t)
//   - immediate builders and the funct3 -> ALU op helper
// -----------------------------------------------------------------------------
package stage_id_pkg;

  localparam int BUS_W      = 32;
  localparam int REG_ADDR_W = 5;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // funct3 for OP / OP-IMM
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct3 for BRANCH
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // funct7 variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Decoder result for one instruction
  typedef struct packed {
    logic [BUS_W-1:0]      imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_op;
    logic                  alu_src_imm;
    logic                  alu_src_pc;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_size;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  illegal;
    logic                  rs1_used;
    logic                  rs2_used;
  } dec_t;

  // Contents of the ID/EX pipeline register; all-zero is a NOP bubble
  typedef struct packed {
    logic [BUS_W-1:0]      rs1;
    logic [BUS_W-1:0]      rs2;
    logic [BUS_W-1:0]      imm;
    logic [BUS_W-1:0]      pc;
    logic [BUS_W-1:0]      pc_plus;
    logic [REG_ADDR_W-1:0] rd;
    logic [3:0]            alu_op;
    logic                  alu_src_imm;
    logic                  alu_src_pc;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [2:0]            mem_size;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  illegal;
  } idex_t;

  function automatic logic [BUS_W-1:0] imm_i(input logic [BUS_W-1:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [BUS_W-1:0] imm_s(input logic [BUS_W-1:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [BUS_W-1:0] imm_b(input logic [BUS_W-1:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [BUS_W-1:0] imm_u(input logic [BUS_W-1:0] i);
    return {i[31:12], 12'h000};
  endfunction

  function automatic logic [BUS_W-1:0] imm_j(input logic [BUS_W-1:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stage_id_if.sv
// -----------------------------------------------------------------------------
// stage_id_if
// ID/EX pipeline register bundle between decode and execute.
//   master : driven by stage_id (all registered)
//   slave  : consumed by the execute stage
// Signals: rs1Out, rs2Out, immOut, rdOut, aluOpOut, aluSrcImmOut, aluSrcPcOut,
//          regWriteOut, memReadOut, memWriteOut, memSizeOut, branchOut,
//          jalOut, jalrOut, pcOut, pcPlusOut, illegalOut.
// -----------------------------------------------------------------------------
interface stage_id_if;
  import stage_id_pkg::*;

  logic [BUS_W-1:0]      rs1Out;
  logic [BUS_W-1:0]      rs2Out;
  logic [BUS_W-1:0]      immOut;
  logic [REG_ADDR_W-1:0] rdOut;
  logic [3:0]            aluOpOut;
  logic                  aluSrcImmOut;
  logic                  aluSrcPcOut;
  logic                  regWriteOut;
  logic                  memReadOut;
  logic                  memWriteOut;
  logic [2:0]            memSizeOut;
  logic                  branchOut;
  logic                  jalOut;
  logic                  jalrOut;
  logic [BUS_W-1:0]      pcOut;
  logic [BUS_W-1:0]      pcPlusOut;
  logic                  illegalOut;

  modport master (
    output rs1Out, rs2Out, immOut, rdOut, aluOpOut, aluSrcImmOut, aluSrcPcOut,
           regWriteOut, memReadOut, memWriteOut, memSizeOut, branchOut,
           jalOut, jalrOut, pcOut, pcPlusOut, illegalOut
  );

  modport slave (
    input rs1Out, rs2Out, immOut, rdOut, aluOpOut, aluSrcImmOut, aluSrcPcOut,
          regWriteOut, memReadOut, memWriteOut, memSizeOut, branchOut,
          jalOut, jalrOut, pcOut, pcPlusOut, illegalOut
  );

endinterface

// File: rtl/stage_id_id_decoder.sv
// -----------------------------------------------------------------------------
// stage_id_id_decoder
// Purely combinational RV32I decoder: instruction -> controls + immediate.
//   inst : instruction word from IF/ID
//   dec  : decoded controls, sign-extended immediate, rd, operand-use flags
// Illegal encodings return all controls 0 with illegal=1; inst==0 is a NOP.
// -----------------------------------------------------------------------------
module stage_id_id_decoder
  import stage_id_pkg::*;
(
  input  logic [BUS_W-1:0] inst,
  output dec_t             dec
);

  logic [6:0]            opcode_s;
  logic [2:0]            funct3_s;
  logic [6:0]            funct7_s;
  logic [REG_ADDR_W-1:0] rd_field_s;
  dec_t                  raw_s;

  assign opcode_s   = inst[6:0];
  assign funct3_s   = inst[14:12];
  assign funct7_s   = inst[31:25];
  assign rd_field_s = inst[11:7];

  // Opcode-level decode, before NOP / illegal / rd==0 clean-up.
  always_comb begin
    raw_s        = '0;
    raw_s.alu_op = ALU_ADD;
    case (opcode_s)
      OPC_LUI: begin
        // The unused rs1 operand is zeroed upstream, so 0 + imm gives the result.
        raw_s.imm         = imm_u(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        raw_s.imm         = imm_u(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.alu_src_pc  = 1'b1;
        raw_s.reg_write   = 1'b1;
      end
      OPC_JAL: begin
        raw_s.imm         = imm_j(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.alu_src_pc  = 1'b1;
        raw_s.reg_write   = 1'b1;
        raw_s.jal         = 1'b1;
      end
      OPC_JALR: begin
        raw_s.imm         = imm_i(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
        raw_s.jalr        = 1'b1;
      end
      OPC_BRANCH: begin
        raw_s.imm    = imm_b(inst);
        raw_s.branch = 1'b1;
        case (funct3_s)
          F3_BEQ, F3_BNE:   raw_s.alu_op = ALU_SUB;
          F3_BLT, F3_BGE:   raw_s.alu_op = ALU_SLT;
          F3_BLTU, F3_BGEU: raw_s.alu_op = ALU_SLTU;
          default:          raw_s.alu_op = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        raw_s.imm         = imm_i(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
        raw_s.mem_read    = 1'b1;
        raw_s.mem_size    = funct3_s;
      end
      OPC_STORE: begin
        raw_s.imm         = imm_s(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.mem_write   = 1'b1;
        raw_s.mem_size    = funct3_s;
      end
      OPC_OP_IMM: begin
        raw_s.imm         = imm_i(inst);
        raw_s.alu_src_imm = 1'b1;
        raw_s.reg_write   = 1'b1;
        // Only the shift-immediates constrain funct7 (it is part of imm elsewhere).
        if (funct3_s == F3_SLL) begin
          if (funct7_s == F7_BASE) begin
            raw_s.alu_op = ALU_SLL;
          end else begin
            raw_s.illegal = 1'b1;
          end
        end else if (funct3_s == F3_SR) begin
          if (funct7_s == F7_BASE) begin
            raw_s.alu_op = ALU_SRL;
          end else if (funct7_s == F7_ALT) begin
            raw_s.alu_op = ALU_SRA;
          end else begin
            raw_s.illegal = 1'b1;
          end
        end else begin
          raw_s.alu_op = alu_from_f3(funct3_s, 1'b0);
        end
      end
      OPC_OP: begin
        // R-type carries no immediate; imm stays 0.
        raw_s.reg_write = 1'b1;
        if (funct7_s == F7_BASE) begin
          raw_s.alu_op = alu_from_f3(funct3_s, 1'b0);
        end else if ((funct7_s == F7_ALT) &&
                     ((funct3_s == F3_ADD_SUB) || (funct3_s == F3_SR))) begin
          raw_s.alu_op = alu_from_f3(funct3_s, 1'b1);
        end else begin
          raw_s.illegal = 1'b1;
        end
      end
      default: begin
        raw_s.illegal = 1'b1;
      end
    endcase
  end

  // Clean-up: IF bubble, illegal squash, rd==0 write suppression, operand use.
  always_comb begin
    dec = raw_s;
    if (inst == '0) begin
      dec = '0;
    end else if (raw_s.illegal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end else if (rd_field_s == '0) begin
      dec.reg_write = 1'b0;
      dec.rd        = '0;
    end else begin
      dec.rd = raw_s.reg_write ? rd_field_s : '0;
    end
    dec.rs1_used = !((opcode_s == OPC_LUI) || (opcode_s == OPC_AUIPC) ||
                     (opcode_s == OPC_JAL));
    dec.rs2_used = (opcode_s == OPC_OP) || (opcode_s == OPC_STORE) ||
                   (opcode_s == OPC_BRANCH);
  end

endmodule

// File: rtl/stage_id.sv
// -----------------------------------------------------------------------------
// stage_id
// RV32I decode stage: decodes the IF/ID instruction, reads operands, detects
// load-use hazards and registers everything into the ID/EX register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall, flush        hold / kill from later stages
//   instIn, pcIn, pcPlusIn  IF/ID contents
//   exMemRead, exRd     load-in-EX information for hazard detection
//   rs1Addr, rs2Addr    combinational regfile read addresses
//   rs1Data, rs2Data    combinational regfile read data
//   hazardStall         combinational load-use stall to IF
//   idex                ID/EX register outputs (stage_id_if.master)
// Optional: ID_WB_BYPASS_EN adds wbRegWrite/wbRd/wbData and forwards the
// write-back result into the operands. Without it the register file must be
// write-before-read.
// -----------------------------------------------------------------------------
module stage_id
  import stage_id_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [BUS_W-1:0]      instIn,
  input  logic [BUS_W-1:0]      pcIn,
  input  logic [BUS_W-1:0]      pcPlusIn,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exRd,
  output logic [REG_ADDR_W-1:0] rs1Addr,
  output logic [REG_ADDR_W-1:0] rs2Addr,
  input  logic [BUS_W-1:0]      rs1Data,
  input  logic [BUS_W-1:0]      rs2Data,
`ifdef ID_WB_BYPASS_EN
  input  logic                  wbRegWrite,
  input  logic [REG_ADDR_W-1:0] wbRd,
  input  logic [BUS_W-1:0]      wbData,
`endif
  output logic                  hazardStall,
  stage_id_if.master            idex
);

  dec_t             dec_s;
  logic [BUS_W-1:0] rs1_val_s;
  logic [BUS_W-1:0] rs2_val_s;
  logic [BUS_W-1:0] rs1_op_s;
  logic [BUS_W-1:0] rs2_op_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;
  logic             hazard_s;
  idex_t            idex_nxt_s;
  idex_t            idex_r;

  assign rs1Addr = instIn[19:15];
  assign rs2Addr = instIn[24:20];

  stage_id_id_decoder u_dec (
    .inst (instIn),
    .dec  (dec_s)
  );

`ifdef ID_WB_BYPASS_EN
  // Forward the write-back result when it targets a register read this cycle.
  always_comb begin
    if (wbRegWrite && (wbRd != '0) && (wbRd == rs1Addr)) begin
      rs1_val_s = wbData;
    end else begin
      rs1_val_s = rs1Data;
    end
    if (wbRegWrite && (wbRd != '0) && (wbRd == rs2Addr)) begin
      rs2_val_s = wbData;
    end else begin
      rs2_val_s = rs2Data;
    end
  end
`else
  assign rs1_val_s = rs1Data;
  assign rs2_val_s = rs2Data;
`endif

  // Unused operand fields hold immediate bits; zero them so EX sees clean values.
  always_comb begin
    if (dec_s.rs1_used && !dec_s.illegal) begin
      rs1_op_s = rs1_val_s;
    end else begin
      rs1_op_s = '0;
    end
    if (dec_s.rs2_used && !dec_s.illegal) begin
      rs2_op_s = rs2_val_s;
    end else begin
      rs2_op_s = '0;
    end
  end

  // Load-use detection; a flush kills the ID instruction so it cannot stall.
  always_comb begin
    rs1_hit_s = dec_s.rs1_used && (exRd == rs1Addr);
    rs2_hit_s = dec_s.rs2_used && (exRd == rs2Addr);
    if (flush) begin
      hazard_s = 1'b0;
    end else begin
      hazard_s = exMemRead && (exRd != '0) && (rs1_hit_s || rs2_hit_s);
    end
  end

  assign hazardStall = hazard_s;

  // Assemble the next ID/EX contents from the decoder and operands.
  always_comb begin
    idex_nxt_s             = '0;
    idex_nxt_s.rs1         = rs1_op_s;
    idex_nxt_s.rs2         = rs2_op_s;
    idex_nxt_s.imm         = dec_s.imm;
    idex_nxt_s.pc          = pcIn;
    idex_nxt_s.pc_plus     = pcPlusIn;
    idex_nxt_s.rd          = dec_s.rd;
    idex_nxt_s.alu_op      = dec_s.alu_op;
    idex_nxt_s.alu_src_imm = dec_s.alu_src_imm;
    idex_nxt_s.alu_src_pc  = dec_s.alu_src_pc;
    idex_nxt_s.reg_write   = dec_s.reg_write;
    idex_nxt_s.mem_read    = dec_s.mem_read;
    idex_nxt_s.mem_write   = dec_s.mem_write;
    idex_nxt_s.mem_size    = dec_s.mem_size;
    idex_nxt_s.branch      = dec_s.branch;
    idex_nxt_s.jal         = dec_s.jal;
    idex_nxt_s.jalr        = dec_s.jalr;
    idex_nxt_s.illegal     = dec_s.illegal;
  end

  // ID/EX register: reset > flush > stall(hold) > load-use bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_r <= '0;
    end else if (flush) begin
      idex_r <= '0;
    end else if (stall) begin
      idex_r <= idex_r;
    end else if (hazard_s) begin
      idex_r <= '0;
    end else begin
      idex_r <= idex_nxt_s;
    end
  end

  assign idex.rs1Out       = idex_r.rs1;
  assign idex.rs2Out       = idex_r.rs2;
  assign idex.immOut       = idex_r.imm;
  assign idex.rdOut        = idex_r.rd;
  assign idex.aluOpOut     = idex_r.alu_op;
  assign idex.aluSrcImmOut = idex_r.alu_src_imm;
  assign idex.aluSrcPcOut  = idex_r.alu_src_pc;
  assign idex.regWriteOut  = idex_r.reg_write;
  assign idex.memReadOut   = idex_r.mem_read;
  assign idex.memWriteOut  = idex_r.mem_write;
  assign idex.memSizeOut   = idex_r.mem_size;
  assign idex.branchOut    = idex_r.branch;
  assign idex.jalOut       = idex_r.jal;
  assign idex.jalrOut      = idex_r.jalr;
  assign idex.pcOut        = idex_r.pc;
  assign idex.pcPlusOut    = idex_r.pc_plus;
  assign idex.illegalOut   = idex_r.illegal;

endmodule

// File: tb/tb_stage_id.sv
// -----------------------------------------------------------------------------
// tb_stage_id
// Directed self-checking bench for stage_id. Each step drives an instruction,
// pushes the expected ID/EX contents to a scoreboard queue and pops/compares
// them one clock later. Bypass steps are compiled with ID_WB_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_stage_id;
  import stage_id_pkg::*;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcplus;
    logic [4:0]  rd;
    logic [3:0]  aluop;
    logic        srcimm;
    logic        srcpc;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [2:0]  memsize;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, exMemRead;
  logic [4:0]  exRd;
  logic [31:0] instIn, pcIn, pcPlusIn;
  logic [4:0]  rs1Addr, rs2Addr;
  logic [31:0] rs1Data, rs2Data;
  logic        hazardStall;
`ifdef ID_WB_BYPASS_EN
  logic        wbRegWrite;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
`endif

  exp_t sb_q[$];
  exp_t prev;
  exp_t e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  stage_id_if idex ();

  stage_id dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .instIn      (instIn),
    .pcIn        (pcIn),
    .pcPlusIn    (pcPlusIn),
    .exMemRead   (exMemRead),
    .exRd        (exRd),
    .rs1Addr     (rs1Addr),
    .rs2Addr     (rs2Addr),
    .rs1Data     (rs1Data),
    .rs2Data     (rs2Data),
`ifdef ID_WB_BYPASS_EN
    .wbRegWrite  (wbRegWrite),
    .wbRd        (wbRd),
    .wbData      (wbData),
`endif
    .hazardStall (hazardStall),
    .idex        (idex)
  );

  // Register file model: x0 = 0, xN = 0x100 + N
  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (32'h0000_0100 + {27'd0, a});
  endfunction

  assign rs1Data = rf_val(rs1Addr);
  assign rs2Data = rf_val(rs2Addr);

  function automatic exp_t base(input logic [31:0] pc);
    exp_t b;
    b        = '0;
    b.pc     = pc;
    b.pcplus = pc + 32'd4;
    return b;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t x;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      x = sb_q.pop_front();
      cmp({tag, ".rs1Out"},   idex.rs1Out,                  x.rs1);
      cmp({tag, ".rs2Out"},   idex.rs2Out,                  x.rs2);
      cmp({tag, ".immOut"},   idex.immOut,                  x.imm);
      cmp({tag, ".pcOut"},    idex.pcOut,                   x.pc);
      cmp({tag, ".pcPlus"},   idex.pcPlusOut,               x.pcplus);
      cmp({tag, ".rdOut"},    {27'd0, idex.rdOut},          {27'd0, x.rd});
      cmp({tag, ".aluOp"},    {28'd0, idex.aluOpOut},       {28'd0, x.aluop});
      cmp({tag, ".srcImm"},   {31'd0, idex.aluSrcImmOut},   {31'd0, x.srcimm});
      cmp({tag, ".srcPc"},    {31'd0, idex.aluSrcPcOut},    {31'd0, x.srcpc});
      cmp({tag, ".regWrite"}, {31'd0, idex.regWriteOut},    {31'd0, x.regwrite});
      cmp({tag, ".memRead"},  {31'd0, idex.memReadOut},     {31'd0, x.memread});
      cmp({tag, ".memWrite"}, {31'd0, idex.memWriteOut},    {31'd0, x.memwrite});
      cmp({tag, ".memSize"},  {29'd0, idex.memSizeOut},     {29'd0, x.memsize});
      cmp({tag, ".branch"},   {31'd0, idex.branchOut},      {31'd0, x.branch});
      cmp({tag, ".jal"},      {31'd0, idex.jalOut},         {31'd0, x.jal});
      cmp({tag, ".jalr"},     {31'd0, idex.jalrOut},        {31'd0, x.jalr});
      cmp({tag, ".illegal"},  {31'd0, idex.illegalOut},     {31'd0, x.illegal});
      prev = x;
    end
  endtask

  // Drive one instruction, check the combinational hazard, then the registered result.
  task automatic step(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                      input exp_t ex, input logic haz);
    instIn   = inst;
    pcIn     = pc;
    pcPlusIn = pc + 32'd4;
    #1;
    cmp({tag, ".hazard"}, {31'd0, hazardStall}, {31'd0, haz});
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; exMemRead = 1'b0; exRd = 5'd0;
    instIn = 32'd0; pcIn = 32'd0; pcPlusIn = 32'd0;
    prev = '0;
`ifdef ID_WB_BYPASS_EN
    wbRegWrite = 1'b0; wbRd = 5'd0; wbData = 32'd0;
`endif

    // Reset for two cycles with ADDI x1,x0,5 presented
    step("rst0", 32'h0050_0093, 32'h100, '0, 1'b0);
    step("rst1", 32'h0050_0093, 32'h100, '0, 1'b0);
    rst = 1'b0;

    e = base(32'h100); e.imm = 32'd5; e.rd = 5'd1; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.regwrite = 1'b1;
    step("addi", 32'h0050_0093, 32'h100, e, 1'b0);

    // Load-use on rs1: LW x2 in EX, ADD x3,x2,x1 in ID
    exMemRead = 1'b1; exRd = 5'd2;
    step("loaduse", 32'h0011_01B3, 32'h104, '0, 1'b1);
    exMemRead = 1'b0;
    e = base(32'h104); e.rs1 = 32'h102; e.rs2 = 32'h101; e.rd = 5'd3;
    e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("add", 32'h0011_01B3, 32'h104, e, 1'b0);

    e = base(32'h108); e.rs1 = 32'h101; e.rs2 = 32'h102; e.imm = 32'd8;
    e.aluop = ALU_ADD; e.srcimm = 1'b1; e.memwrite = 1'b1; e.memsize = 3'd2;
    step("sw", 32'h0020_A423, 32'h108, e, 1'b0);

    e = base(32'h10C); e.imm = 32'h1234_5000; e.rd = 5'd5; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.regwrite = 1'b1;
    step("lui", 32'h1234_52B7, 32'h10C, e, 1'b0);

    e = base(32'h110); e.rs1 = 32'h101; e.rd = 5'd2; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.regwrite = 1'b1; e.memread = 1'b1; e.memsize = 3'd2;
    step("lw", 32'h0000_A103, 32'h110, e, 1'b0);

    e = base(32'h114); e.rs1 = 32'h101; e.rs2 = 32'h102; e.imm = 32'd16;
    e.aluop = ALU_SUB; e.branch = 1'b1;
    step("beq", 32'h0020_8863, 32'h114, e, 1'b0);

    e = base(32'h118); e.imm = 32'hFFFF_FFFC; e.rd = 5'd1; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.srcpc = 1'b1; e.regwrite = 1'b1; e.jal = 1'b1;
    step("jal", 32'hFFDF_F0EF, 32'h118, e, 1'b0);

    e = base(32'h11C); e.rs1 = 32'h101; e.imm = 32'h0000_0403; e.rd = 5'd4;
    e.aluop = ALU_SRA; e.srcimm = 1'b1; e.regwrite = 1'b1;
    step("srai", 32'h4030_D213, 32'h11C, e, 1'b0);

    e = base(32'h120); e.illegal = 1'b1;
    step("slli_f7", 32'h4030_9213, 32'h120, e, 1'b0);
    e = base(32'h124); e.illegal = 1'b1;
    step("op_f7", 32'h0211_01B3, 32'h124, e, 1'b0);

    // ADDI x0,x0,0: rd==0 suppresses the write
    e = base(32'h128); e.aluop = ALU_ADD; e.srcimm = 1'b1;
    step("rd0", 32'h0000_0013, 32'h128, e, 1'b0);

    // Load-use on rs2 only: ADD x3,x2,x1 with load to x1
    exMemRead = 1'b1; exRd = 5'd1;
    step("haz_rs2", 32'h0011_01B3, 32'h12C, '0, 1'b1);
    // exRd==0 never stalls: ADD x3,x0,x1
    exRd = 5'd0;
    e = base(32'h130); e.rs2 = 32'h101; e.rd = 5'd3; e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("exrd0", 32'h0010_01B3, 32'h130, e, 1'b0);
    // ADDI x1,x0,5 has rs2 field 5, but rs2 is unused
    exRd = 5'd5;
    e = base(32'h134); e.imm = 32'd5; e.rd = 5'd1; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.regwrite = 1'b1;
    step("rs2unused", 32'h0050_0093, 32'h134, e, 1'b0);

    // flush + stall together with a hazard present -> bubble, hazard masked
    exRd = 5'd2; flush = 1'b1; stall = 1'b1;
    step("flush_stall", 32'h0011_01B3, 32'h138, '0, 1'b0);
    flush = 1'b0; stall = 1'b0; exMemRead = 1'b0;

    e = base(32'h200); e.imm = 32'd5; e.rd = 5'd1; e.aluop = ALU_ADD;
    e.srcimm = 1'b1; e.regwrite = 1'b1;
    step("addi2", 32'h0050_0093, 32'h200, e, 1'b0);

    // stall with hazard present -> hold, no bubble
    stall = 1'b1; exMemRead = 1'b1; exRd = 5'd2;
    step("stall_haz", 32'h0011_01B3, 32'h204, prev, 1'b1);
    step("stall_haz2", 32'h0011_01B3, 32'h204, prev, 1'b1);

    // reset wins over stall
    rst = 1'b1;
    step("rst_stall", 32'h0011_01B3, 32'h204, '0, 1'b1);
    rst = 1'b0; stall = 1'b0; exMemRead = 1'b0;

    e = base(32'h300); e.illegal = 1'b1;
    step("all_ones", 32'hFFFF_FFFF, 32'h300, e, 1'b0);
    e = base(32'h304);
    step("zero_inst", 32'h0000_0000, 32'h304, e, 1'b0);

`ifdef ID_WB_BYPASS_EN
    wbRegWrite = 1'b1; wbRd = 5'd2; wbData = 32'hDEAD_BEEF;
    e = base(32'h400); e.rs1 = 32'hDEAD_BEEF; e.rs2 = 32'h101; e.rd = 5'd3;
    e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("byp_rs1", 32'h0011_01B3, 32'h400, e, 1'b0);
    wbRd = 5'd1;
    e = base(32'h404); e.rs1 = 32'h102; e.rs2 = 32'hDEAD_BEEF; e.rd = 5'd3;
    e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("byp_rs2", 32'h0011_01B3, 32'h404, e, 1'b0);
    wbRd = 5'd0;
    e = base(32'h408); e.rs2 = 32'h101; e.rd = 5'd3; e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("byp_x0", 32'h0010_01B3, 32'h408, e, 1'b0);
    wbRegWrite = 1'b0; wbRd = 5'd2;
    e = base(32'h40C); e.rs1 = 32'h102; e.rs2 = 32'h101; e.rd = 5'd3;
    e.aluop = ALU_ADD; e.regwrite = 1'b1;
    step("byp_off", 32'h0011_01B3, 32'h40C, e, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
